// File: rtl/memory_fill_engine.sv
// Sweeps an SRAM address window, either writing a generated pattern or reading it
// back through a READ_LATENCY-deep tag pipe and flagging the first mismatch.
module memory_fill_engine #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  pause,
  input  logic                  verify,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] error_addr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] expected;
  } tag_t;

  state_t                state;
  logic                  cfg_verify;
  logic [1:0]            cfg_mode;
  logic [ADDR_WIDTH-1:0] cfg_start;
  logic [ADDR_WIDTH:0]   cfg_length;
  logic [DATA_WIDTH-1:0] cfg_pattern;
  logic [ADDR_WIDTH:0]   index;
  tag_t                  pipe [READ_LATENCY];

  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_data;
  logic [ADDR_WIDTH:0]   index_next;
  logic                  last_issue;
  tag_t                  tail;
  logic                  cmp_fail;
  logic                  drain_last;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    issue_addr = cfg_start + index[ADDR_WIDTH-1:0];
    issue_data = cfg_pattern;
    case (cfg_mode)
      2'd0: issue_data = cfg_pattern;
      2'd1: issue_data = cfg_pattern + DATA_WIDTH'(index);
      2'd2: issue_data = DATA_WIDTH'(issue_addr);
      2'd3: issue_data = index[0] ? ~cfg_pattern : cfg_pattern;
    endcase
    index_next = index + 1'b1;
    last_issue = (index_next == cfg_length);
    tail       = pipe[READ_LATENCY-1];
    cmp_fail   = tail.valid && (data_read != tail.expected);
    // The last compare happens when only the exit stage still holds a valid tag.
    drain_last = 1'b1;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      if (pipe[i].valid) drain_last = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the small tag pipe is
  // reset too, since a stale valid bit would otherwise produce a phantom compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wren        <= 1'b0;
      address     <= '0;
      data_write  <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_addr  <= '0;
      cfg_verify  <= 1'b0;
      cfg_mode    <= '0;
      cfg_start   <= '0;
      cfg_length  <= '0;
      cfg_pattern <= '0;
      index       <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '0;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];

      if (!enable) begin
        state      <= S_IDLE;
        wren       <= 1'b0;
        address    <= '0;
        data_write <= '0;
        done       <= 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      end else begin
        if ((state == S_RUN || state == S_DRAIN) && cmp_fail && !error) begin
          error      <= 1'b1;
          error_addr <= tail.addr;
        end

        case (state)
          S_IDLE: begin
            cfg_verify  <= verify;
            cfg_mode    <= mode;
            cfg_start   <= start_addr;
            cfg_length  <= length;
            cfg_pattern <= pattern;
            index       <= '0;
            error       <= 1'b0;
            error_addr  <= '0;
            state       <= (length == '0) ? S_DONE : S_RUN;
          end
          S_RUN: begin
            if (pause) begin
              wren <= 1'b0;
            end else begin
              address <= issue_addr;
              wren    <= !cfg_verify;
              if (cfg_verify) begin
                pipe[0] <= '{valid: 1'b1, addr: issue_addr, expected: issue_data};
              end else begin
                data_write <= issue_data;
              end
              index <= index_next;
              if (last_issue) state <= cfg_verify ? S_DRAIN : S_DONE;
            end
          end
          S_DRAIN: begin
            wren <= 1'b0;
            if (drain_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_DONE: begin
            done <= 1'b1;
            wren <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_fill_engine.sv
// Self-checking bench for memory_fill_engine: table-driven runs with a write scoreboard
// and a backing-memory model, plus abort, reset and full-window sequences.
module tb_memory_fill_engine;

  logic        clk;
  logic        reset_n;
  logic        enable, pause, verify;
  logic [1:0]  mode;
  logic [17:0] start_addr;
  logic [18:0] length;
  logic [31:0] pattern, data_read;
  logic        wren, done, error;
  logic [17:0] address, error_addr;
  logic [31:0] data_write;

  // Small instance: full 2^ADDR_WIDTH window and READ_LATENCY=1.
  logic        s_enable, s_pause, s_verify;
  logic [1:0]  s_mode;
  logic [3:0]  s_start_addr;
  logic [4:0]  s_length;
  logic [7:0]  s_pattern, s_data_read;
  logic        s_wren, s_done, s_error;
  logic [3:0]  s_address, s_error_addr;
  logic [7:0]  s_data_write;

  memory_fill_engine #(.ADDR_WIDTH(18), .DATA_WIDTH(32), .READ_LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pause(pause), .verify(verify),
    .mode(mode), .start_addr(start_addr), .length(length), .pattern(pattern),
    .data_read(data_read), .wren(wren), .address(address), .data_write(data_write),
    .done(done), .error(error), .error_addr(error_addr)
  );

  memory_fill_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(s_enable), .pause(s_pause), .verify(s_verify),
    .mode(s_mode), .start_addr(s_start_addr), .length(s_length), .pattern(s_pattern),
    .data_read(s_data_read), .wren(s_wren), .address(s_address), .data_write(s_data_write),
    .done(s_done), .error(s_error), .error_addr(s_error_addr)
  );

  // Read data for the small instance is address-as-data, corrupted at address 9.
  assign s_data_read = {4'b0, s_address} ^ ((s_address == 4'd9) ? 8'h40 : 8'h00);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        verify;
    logic [1:0]  mode;
    logic [17:0] start;
    int          len;
    logic [31:0] pattern;
    int          pause_at;
    int          pause_len;
    bit          corrupt;
    int          exp_done;
    logic        exp_error;
    logic [17:0] exp_err_addr;
  } vec_t;

  typedef struct {
    logic [17:0] addr;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb [$];
  logic [31:0] mem [logic [17:0]];
  logic [17:0] prev_addr = '0;
  bit          corrupt_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input vec_t v, input int k);
    logic [17:0] a;
    a = 18'(v.start + 18'(k));
    case (v.mode)
      2'd0:    return v.pattern;
      2'd1:    return v.pattern + 32'(k);
      2'd2:    return {14'b0, a};
      default: return k[0] ? ~v.pattern : v.pattern;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input logic [17:0] a);
    logic [31:0] w;
    w = mem.exists(a) ? mem[a] : 32'h0;
    if (corrupt_on && (a == 18'd5 || a == 18'd6)) w = w ^ 32'h0001_0000;
    return w;
  endfunction

  // One clock: outputs are sampled on the falling edge, where the SRAM model also acts.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (wren) mem[address] = data_write;
    data_read = rd_word(prev_addr);
    prev_addr = address;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int          writes, done_edge, hold_bad;
    logic [17:0] pa;
    logic [31:0] pd;
    exp_t        e;
    sb.delete();
    if (!v.verify) begin
      for (int k = 0; k < v.len; k++) sb.push_back('{addr: 18'(v.start + 18'(k)), data: model(v, k)});
    end
    corrupt_on = v.corrupt;
    verify = v.verify; mode = v.mode; start_addr = v.start; length = 19'(v.len);
    pattern = v.pattern; pause = 1'b0; enable = 1'b1;
    tick();
    writes = 0; done_edge = -1; hold_bad = 0;
    for (int n = 1; n <= 2 * v.len + 20 && done_edge < 0; n++) begin
      pause = (n >= v.pause_at) && (n < v.pause_at + v.pause_len);
      pa = address;
      pd = data_write;
      tick();
      if (pause && (wren || address != pa || data_write != pd)) hold_bad++;
      if (wren) begin
        writes++;
        if (sb.size() == 0) check({tag, " unexpected write"}, 1, 0);
        else begin
          e = sb.pop_front();
          check({tag, " wr addr"}, address, e.addr);
          check({tag, " wr data"}, data_write, e.data);
        end
      end
      if (done) done_edge = n;
    end
    pause = 1'b0;
    check({tag, " done edge"}, done_edge, v.exp_done);
    check({tag, " write count"}, writes, v.verify ? 0 : v.len);
    if (v.pause_len > 0) check({tag, " pause hold"}, hold_bad, 0);
    check({tag, " error"}, error, v.exp_error);
    if (v.exp_error) check({tag, " error_addr"}, error_addr, v.exp_err_addr);
    tick();
    tick();
    check({tag, " done held, no restart"}, {done, wren}, 2'b10);
    enable = 1'b0;
    tick();
    check({tag, " done/wren fall"}, {done, wren}, 2'b00);
    check({tag, " error retained"}, error, v.exp_error);
    corrupt_on = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    int cnt, dedge;
    logic [3:0] sa;

    tbl[0] = '{1'b0, 2'd0, 18'h00000, 64, 32'h77553311, 0, 0, 1'b0, 65, 1'b0, 18'h0};
    tbl[1] = '{1'b0, 2'd1, 18'h3FFFE,  4, 32'hFFFFFFFF, 0, 0, 1'b0,  5, 1'b0, 18'h0};
    tbl[2] = '{1'b1, 2'd1, 18'h3FFFE,  4, 32'hFFFFFFFF, 0, 0, 1'b0,  6, 1'b0, 18'h0};
    tbl[3] = '{1'b0, 2'd3, 18'h00100,  3, 32'hA5A50F0F, 2, 2, 1'b0,  6, 1'b0, 18'h0};
    tbl[4] = '{1'b1, 2'd3, 18'h00100,  3, 32'hA5A50F0F, 0, 0, 1'b0,  5, 1'b0, 18'h0};
    tbl[5] = '{1'b0, 2'd2, 18'h00000,  8, 32'h0,        0, 0, 1'b0,  9, 1'b0, 18'h0};
    tbl[6] = '{1'b1, 2'd2, 18'h00000,  8, 32'h0,        0, 0, 1'b1, 10, 1'b1, 18'd5};
    tbl[7] = '{1'b0, 2'd2, 18'h3FFF0, 20, 32'h0,        0, 0, 1'b0, 21, 1'b0, 18'h0};
    tbl[8] = '{1'b1, 2'd2, 18'h3FFF0, 20, 32'h0,        4, 3, 1'b0, 25, 1'b0, 18'h0};
    tbl[9] = '{1'b0, 2'd0, 18'h00000,  0, 32'h12345678, 0, 0, 1'b0,  1, 1'b0, 18'h0};

    reset_n = 1'b0; enable = 1'b0; pause = 1'b0; verify = 1'b0; mode = '0;
    start_addr = '0; length = '0; pattern = '0; data_read = '0;
    s_enable = 1'b0; s_pause = 1'b0; s_verify = 1'b0; s_mode = 2'd2;
    s_start_addr = 4'd5; s_length = 5'd16; s_pattern = 8'h00;
    #23;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("reset outputs", {wren, address, data_write, done, error, error_addr}, '0);
    check("reset outputs small", {s_wren, s_address, s_data_write, s_done, s_error, s_error_addr}, '0);

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Abort after three writes, then restart from start_addr.
    verify = 1'b0; mode = 2'd0; start_addr = 18'h10; length = 19'd10;
    pattern = 32'h12345678; enable = 1'b1;
    tick();
    tick(); tick(); tick();
    check("abort third write", {wren, address}, {1'b1, 18'h12});
    enable = 1'b0;
    tick();
    check("abort wren/done", {done, wren}, 2'b00);
    check("abort bus cleared", {address, data_write}, '0);
    enable = 1'b1;
    tick();
    tick();
    check("restart first access", {wren, address, data_write}, {1'b1, 18'h10, 32'h12345678});
    dedge = -1;
    for (int n = 2; n <= 40 && dedge < 0; n++) begin
      tick();
      if (done) dedge = n;
    end
    check("restart done edge", dedge, 11);
    enable = 1'b0;
    tick();

    // Async reset in the middle of a verify run that already flagged an error.
    corrupt_on = 1'b1;
    verify = 1'b1; mode = 2'd2; start_addr = 18'h0; length = 19'd8; enable = 1'b1;
    tick();
    for (int n = 1; n <= 9; n++) tick();
    check("pre-reset error", {done, error, error_addr}, {1'b0, 1'b1, 18'd5});
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("async reset outputs", {wren, address, data_write, done, error, error_addr}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    corrupt_on = 1'b0;
    tick(); tick();
    check("idle after reset", {wren, done, error}, 3'b000);
    run_op('{1'b0, 2'd0, 18'h00200, 3, 32'hCAFEF00D, 0, 0, 1'b0, 4, 1'b0, 18'h0}, "post-reset");

    // Full 16-word window on the small instance, wrapping from address 5.
    s_enable = 1'b1;
    tick();
    cnt = 0; dedge = -1;
    for (int n = 1; n <= 40 && dedge < 0; n++) begin
      tick();
      if (s_wren) begin
        sa = 4'(4'd5 + 4'(cnt));
        check("small wr addr", s_address, sa);
        check("small wr data", s_data_write, {4'b0, sa});
        cnt++;
      end
      if (s_done) dedge = n;
    end
    check("small write count", cnt, 16);
    check("small write done edge", dedge, 17);
    s_enable = 1'b0;
    tick();
    s_verify = 1'b1; s_enable = 1'b1;
    tick();
    cnt = 0; dedge = -1;
    for (int n = 1; n <= 40 && dedge < 0; n++) begin
      tick();
      if (s_wren) cnt++;
      if (s_done) dedge = n;
    end
    check("small verify no writes", cnt, 0);
    check("small verify done edge", dedge, 17);
    check("small verify error", {s_error, s_error_addr}, {1'b1, 4'd9});
    s_enable = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
